// File: rtl/simd_pkg.sv
// Shared types for the SIMD array sequencer slice.
// Ports: none (package of op/state enums and sizing helpers).
package simd_pkg;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MAC,
        OP_RSVD
    } simd_op_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        EXEC,
        OUT
    } seq_state_t;

    // Counter width able to hold values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/simd_watchdog.sv
// EXEC-phase watchdog: zeroed on clear, counts while enabled, flags expiry.
// Ports: i_clk, i_rst (sync, active-high), clear, enable -> first, expired.
module simd_watchdog
    import simd_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic first,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Saturates at LAST so a long stay in EXEC never wraps to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds k-1 during the k-th enabled cycle.
    assign first   = (cnt == '0);
    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/simd_array_sequencer.sv
// Command sequencer: streams operand chunks into one simd_array and returns results.
// Ports: cmd (valid/ready, op, len), opd (valid/ready, a, b), res (valid/ready, data, last),
//        array side (rstn, op, run, a, b, valid, res), status (busy, done, err).
module simd_array_sequencer
    import simd_pkg::*;
#(
    parameter int UNIT_SIZE = 32,
    parameter int WIDTH     = 4,
    parameter int LEN_W     = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [1:0]                 i_cmd_op,
    input  logic [LEN_W-1:0]           i_cmd_len,
    input  logic                       i_opd_valid,
    output logic                       o_opd_ready,
    input  logic [WIDTH*UNIT_SIZE-1:0] i_opd_a,
    input  logic [WIDTH*UNIT_SIZE-1:0] i_opd_b,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [WIDTH*UNIT_SIZE-1:0] o_res_data,
    output logic                       o_res_last,
    output logic                       o_arr_rstn,
    output logic [1:0]                 o_arr_op,
    output logic                       o_arr_run,
    output logic [WIDTH*UNIT_SIZE-1:0] o_arr_a,
    output logic [WIDTH*UNIT_SIZE-1:0] o_arr_b,
    input  logic                       i_arr_valid,
    input  logic [WIDTH*UNIT_SIZE-1:0] i_arr_res,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int DW = WIDTH * UNIT_SIZE;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    seq_state_t       state;
    seq_state_t       state_nx;
    simd_op_t         op_q;
    logic [LEN_W-1:0] rem_q;
    logic             err_q;
    logic             done_q;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic [DW-1:0]    res_q;

    logic cmd_hs;
    logic opd_hs;
    logic arr_hit;
    logic cmd_bad;
    logic wd_first;
    logic wd_expired;

    assign cmd_hs  = i_cmd_valid && (state == IDLE);
    assign opd_hs  = i_opd_valid && (state == LOAD);
    assign cmd_bad = (simd_op_t'(i_cmd_op) == OP_RSVD);
    // The array's valid is stale in the first EXEC cycle.
    assign arr_hit = (state == EXEC) && !wd_first && i_arr_valid;

    simd_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clear  (opd_hs),
        .enable (state == EXEC),
        .first  (wd_first),
        .expired(wd_expired)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (i_cmd_valid && !cmd_bad && i_cmd_len != '0) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: state_nx = LOAD;
            LOAD: begin
                if (i_opd_valid) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (arr_hit) begin
                    // MAC only reports once, after its final chunk.
                    if (op_q == OP_MAC && rem_q != ONE) begin
                        state_nx = LOAD;
                    end else begin
                        state_nx = OUT;
                    end
                end else if (wd_expired) begin
                    state_nx = IDLE;
                end
            end
            OUT: begin
                if (i_res_ready) begin
                    state_nx = (rem_q == '0) ? IDLE : LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            rem_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
        end else begin
            state  <= state_nx;
            // Every return to IDLE, or an immediate finish, ends a command.
            done_q <= (state_nx == IDLE) && ((state != IDLE) || cmd_hs);
            if (cmd_hs) begin
                op_q  <= simd_op_t'(i_cmd_op);
                rem_q <= i_cmd_len;
                err_q <= cmd_bad;
            end else if (arr_hit) begin
                res_q <= i_arr_res;
                rem_q <= rem_q - ONE;
            end else if (state == EXEC && wd_expired) begin
                err_q <= 1'b1;
            end
            if (opd_hs) begin
                a_q <= i_opd_a;
                b_q <= i_opd_b;
            end
        end
    end

    assign o_cmd_ready = (state == IDLE);
    assign o_opd_ready = (state == LOAD);
    assign o_res_valid = (state == OUT);
    assign o_res_data  = res_q;
    assign o_res_last  = (state == OUT) && (rem_q == '0);
    assign o_arr_rstn  = !(i_rst || state == CLEAR);
    assign o_arr_op    = op_q;
    assign o_arr_run   = (state == EXEC);
    assign o_arr_a     = a_q;
    assign o_arr_b     = b_q;
    assign o_busy      = (state != IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_simd_array_sequencer.sv
// Self-checking bench for simd_array_sequencer with a behavioural array responder.
// Ports: none (top-level testbench).
module tb_simd_array_sequencer;

    localparam int US = 32;
    localparam int W  = 4;
    localparam int LW = 8;
    localparam int TO = 64;
    localparam int DW = US * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [LW-1:0] cmd_len = '0;
    logic          opd_valid = 1'b0;
    logic          opd_ready;
    logic [DW-1:0] opd_a = '0;
    logic [DW-1:0] opd_b = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          res_last;
    logic          arr_rstn;
    logic [1:0]    arr_op;
    logic          arr_run;
    logic [DW-1:0] arr_a;
    logic [DW-1:0] arr_b;
    logic          arr_valid = 1'b0;
    logic [DW-1:0] arr_res = '0;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    simd_array_sequencer #(
        .UNIT_SIZE(US), .WIDTH(W), .LEN_W(LW), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_len(cmd_len),
        .i_opd_valid(opd_valid), .o_opd_ready(opd_ready),
        .i_opd_a(opd_a), .i_opd_b(opd_b),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_last(res_last),
        .o_arr_rstn(arr_rstn), .o_arr_op(arr_op), .o_arr_run(arr_run),
        .o_arr_a(arr_a), .o_arr_b(arr_b),
        .i_arr_valid(arr_valid), .i_arr_res(arr_res),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    // Behavioural SIMD array: acts on run rising edge, answers after a random delay.
    logic          run_d = 1'b0;
    logic [DW-1:0] acc = '0;
    int            dly = 0;
    logic          arr_hang = 1'b0;

    function automatic logic [DW-1:0] arr_fn(input logic [1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < W; l++) begin
            case (op)
                2'd0: r[l*US +: US] = a[l*US +: US] + b[l*US +: US];
                2'd1: r[l*US +: US] = a[l*US +: US] - b[l*US +: US];
                2'd2: r[l*US +: US] = c[l*US +: US] + a[l*US +: US] * b[l*US +: US];
                default: r[l*US +: US] = '0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        run_d <= arr_run;
        if (!arr_rstn) begin
            acc       <= '0;
            arr_valid <= 1'b0;
            arr_res   <= '0;
            dly       <= 0;
        end else if (arr_run && !run_d) begin
            arr_res   <= arr_fn(arr_op, arr_a, arr_b, acc);
            if (arr_op == 2'd2) acc <= arr_fn(arr_op, arr_a, arr_b, acc);
            arr_valid <= 1'b0;
            dly       <= int'($urandom_range(0, 2));
        end else if (!arr_run) begin
            arr_valid <= 1'b0;
        end else if (dly > 0) begin
            dly <= dly - 1;
        end else if (!arr_hang) begin
            arr_valid <= 1'b1;
        end
    end

    // Stimulus chunks, reference expectations and observations.
    logic [DW-1:0] ca[$];
    logic [DW-1:0] cb[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt, run_edges, run_cyc, rstn_low, opd_hs, unstable, res_hold;
    logic done_err, hung, rstn_first;
    logic post_busy, post_rv, post_run, post_rstn, post_err;

    // Reference: plain lane arithmetic over the whole chunk list.
    task automatic model(input logic [1:0] op);
        logic [US-1:0] x, y;
        logic [DW-1:0] r, m;
        exp_d.delete();
        exp_l.delete();
        m = '0;
        for (int k = 0; k < ca.size(); k++) begin
            r = '0;
            for (int l = 0; l < W; l++) begin
                x = ca[k][l*US +: US];
                y = cb[k][l*US +: US];
                if (op == 2'd0) r[l*US +: US] = x + y;
                else if (op == 2'd1) r[l*US +: US] = x - y;
                else m[l*US +: US] = m[l*US +: US] + x * y;
            end
            if (op != 2'd2) begin
                exp_d.push_back(r);
                exp_l.push_back(k == ca.size() - 1);
            end
        end
        if (op == 2'd2) begin
            exp_d.push_back(m);
            exp_l.push_back(1'b1);
        end
    endtask

    task automatic fill(input int n, input bit rnd, input logic [US-1:0] va,
                        input logic [US-1:0] vb);
        logic [DW-1:0] a, b;
        ca.delete();
        cb.delete();
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < W; l++) begin
                a[l*US +: US] = rnd ? $urandom : va + US'(l);
                b[l*US +: US] = rnd ? $urandom : vb * US'(l);
            end
            ca.push_back(a);
            cb.push_back(b);
        end
    endtask

    // Drives one command; abort>0 asserts reset during EXEC of that chunk.
    task automatic drive_cmd(input logic [1:0] op, input logic [LW-1:0] len,
                             input int budget, input int abort);
        int idx, stall;
        logic prev_run, waiting, fin;
        logic [DW-1:0] held;
        got_d.delete();
        got_l.delete();
        done_cnt = 0; run_edges = 0; run_cyc = 0; rstn_low = 0;
        opd_hs = 0; unstable = 0; done_err = 1'b0; hung = 1'b0;
        idx = 0; stall = res_hold; prev_run = 1'b0; waiting = 1'b0;
        fin = 1'b0; held = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        rstn_first = arr_rstn;
        for (int c = 0; c < budget && !fin; c++) begin
            if (done) begin done_cnt++; done_err = err; fin = 1'b1; end
            if (arr_run && !prev_run) run_edges++;
            if (arr_run) run_cyc++;
            prev_run = arr_run;
            if (!arr_rstn) rstn_low++;
            if (waiting && (!res_valid || res_data !== held || opd_ready)) unstable++;
            if (res_valid) begin
                held = res_data;
                if (stall > 0) begin
                    res_ready = 1'b0; stall--; waiting = 1'b1;
                end else begin
                    res_ready = 1'b1; waiting = 1'b0;
                    got_d.push_back(res_data);
                    got_l.push_back(res_last);
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
                waiting = 1'b0;
            end
            if (idx < ca.size()) begin
                opd_valid = 1'b1; opd_a = ca[idx]; opd_b = cb[idx];
                if (opd_ready) begin idx++; opd_hs++; end
            end else begin
                opd_valid = 1'b0;
            end
            if (abort > 0 && run_edges == abort && arr_run) begin
                rst = 1'b1; fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) hung = 1'b1;
        opd_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        if (done) done_cnt++;
        post_busy = busy; post_rv = res_valid; post_run = arr_run;
        post_rstn = arr_rstn; post_err = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%0b exp=0", res_valid); end
        total++; if (arr_run !== 1'b0) begin bad++; $display("FAIL rst_run got=%0b exp=0", arr_run); end
        total++; if (arr_rstn !== 1'b0) begin bad++; $display("FAIL rst_arr_rstn got=%0b exp=0", arr_rstn); end
        total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL rst_done_err got=%b exp=00", {done, err}); end
        total++; if ({res_data, arr_a, arr_b} !== '0) begin bad++; $display("FAIL rst_data got=%0h exp=0", res_data); end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({cmd_ready, arr_rstn} !== 2'b11) begin bad++; $display("FAIL rst_release got=%b exp=11", {cmd_ready, arr_rstn}); end
    endtask

    task automatic check_results(input string nm);
        total++;
        if (got_d.size() !== exp_d.size() || hung) begin
            bad++; $display("FAIL %s_count got=%0d exp=%0d hung=%0b", nm, got_d.size(), exp_d.size(), hung);
        end
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
                bad++; $display("FAIL %s_res%0d got=%0h/%0b exp=%0h/%0b", nm, k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
        total++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            bad++; $display("FAIL %s_done got=%0d/%0b exp=1/0", nm, done_cnt, done_err);
        end
    endtask

    task automatic test_add();
        fill(3, 0, 0, 10);
        model(2'd0);
        res_hold = 0;
        drive_cmd(2'd0, 8'd3, 300, 0);
        check_results("add");
        total++; if (run_edges !== 3) begin bad++; $display("FAIL add_run_edges got=%0d exp=3", run_edges); end
    endtask

    task automatic test_mac();
        fill(4, 0, 2, 0);
        for (int k = 0; k < 4; k++) begin
            ca[k] = {W{32'd2}};
            cb[k] = {W{32'd3}};
        end
        model(2'd2);
        res_hold = 0;
        drive_cmd(2'd2, 8'd4, 400, 0);
        check_results("mac");
        total++;
        if (rstn_first !== 1'b0 || rstn_low !== 1) begin
            bad++; $display("FAIL mac_clear got=%0b/%0d exp=0/1", rstn_first, rstn_low);
        end
    endtask

    task automatic test_stall();
        fill(2, 1, 0, 0);
        model(2'd1);
        res_hold = 5;
        drive_cmd(2'd1, 8'd2, 300, 0);
        check_results("sub_stall");
        total++; if (unstable !== 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", unstable); end
    endtask

    task automatic test_timeout();
        fill(2, 1, 0, 0);
        res_hold = 0;
        arr_hang = 1'b1;
        drive_cmd(2'd0, 8'd2, 300, 0);
        arr_hang = 1'b0;
        total++; if (done_cnt !== 1 || done_err !== 1'b1) begin bad++; $display("FAIL wd_done got=%0d/%0b exp=1/1", done_cnt, done_err); end
        total++; if (run_cyc !== TO) begin bad++; $display("FAIL wd_cycles got=%0d exp=%0d", run_cyc, TO); end
        total++; if (opd_hs !== 1 || got_d.size() !== 0) begin bad++; $display("FAIL wd_traffic got=%0d/%0d exp=1/0", opd_hs, got_d.size()); end
        total++; if ({post_busy, post_err} !== 2'b01) begin bad++; $display("FAIL wd_idle got=%b exp=01", {post_busy, post_err}); end
        ca.delete(); cb.delete();
        drive_cmd(2'd0, 8'd0, 20, 0);
        total++; if (done_cnt !== 1 || done_err !== 1'b0) begin bad++; $display("FAIL wd_err_clear got=%0d/%0b exp=1/0", done_cnt, done_err); end
    endtask

    task automatic test_special();
        fill(2, 1, 0, 0);
        res_hold = 0;
        drive_cmd(2'd3, 8'd2, 20, 0);
        total++; if (done_cnt !== 1 || done_err !== 1'b1) begin bad++; $display("FAIL rsvd_done got=%0d/%0b exp=1/1", done_cnt, done_err); end
        total++; if (opd_hs !== 0 || run_edges !== 0) begin bad++; $display("FAIL rsvd_traffic got=%0d/%0d exp=0/0", opd_hs, run_edges); end
        drive_cmd(2'd0, 8'd0, 20, 0);
        total++; if (done_cnt !== 1 || done_err !== 1'b0) begin bad++; $display("FAIL len0_done got=%0d/%0b exp=1/0", done_cnt, done_err); end
        total++; if (opd_hs !== 0 || run_cyc !== 0 || rstn_low !== 0) begin bad++; $display("FAIL len0_traffic got=%0d/%0d/%0d exp=0/0/0", opd_hs, run_cyc, rstn_low); end
    endtask

    task automatic test_mid_reset();
        fill(3, 1, 0, 0);
        res_hold = 0;
        drive_cmd(2'd0, 8'd3, 300, 2);
        total++;
        if ({post_busy, post_rv, post_run, post_rstn} !== 4'b0000 || done_cnt !== 0) begin
            bad++; $display("FAIL midrst_state got=%b done=%0d exp=0000 done=0", {post_busy, post_rv, post_run, post_rstn}, done_cnt);
        end
        rst = 1'b0;
        fill(3, 1, 0, 0);
        model(2'd0);
        drive_cmd(2'd0, 8'd3, 300, 0);
        check_results("midrst_rerun");
    endtask

    task automatic test_random();
        logic [1:0] op;
        int n;
        for (int it = 0; it < 6; it++) begin
            op = 2'($urandom_range(0, 2));
            n = int'($urandom_range(1, 4));
            fill(n, 1, 0, 0);
            model(op);
            res_hold = int'($urandom_range(0, 2));
            drive_cmd(op, LW'(n), 400, 0);
            check_results("rand");
            total++; if (opd_hs !== n || run_edges !== n) begin bad++; $display("FAIL rand_chunks got=%0d/%0d exp=%0d", opd_hs, run_edges, n); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mac();
        test_stall();
        test_timeout();
        test_special();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
